// File: rtl/seq_divider_32.sv
// seq_divider_32: multi-cycle signed integer divider.
// Restoring shift-subtract, one quotient bit per clock, followed by a
// sign-fixup cycle. Quotient truncates toward zero; divide-by-zero raises
// data_exception with a zero result. A start pulse in any state restarts
// the unit with the newly presented operands.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0]   ONE_X    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Magnitude of a two's complement value. The most negative value maps to
  // itself, which read as unsigned is exactly 2^(WIDTH-1), so the unsigned
  // datapath still produces the right quotient magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + ONE_W;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Registered state and datapath
  state_t           r_state;
  logic [WIDTH-1:0] r_quo;      // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0] r_rem;      // partial remainder, always < divisor
  logic [WIDTH-1:0] r_div;      // divisor magnitude
  logic             r_sign_q;   // quotient must be negated at fixup
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic             w_sign_q_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_exc_nxt;
  logic             w_rdy_nxt;
  logic             w_busy_nxt;

  // Subtract step: shifted remainder minus divisor, done as an add of the
  // inverted divisor with carry-in 1, one bit wider than the operands so the
  // top bit is the sign of the trial remainder.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_trial_neg;

  assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = w_rem_sh + {1'b1, ~r_div} + ONE_X;
  assign w_trial_neg = w_trial[WIDTH];

  // Next-state, datapath and output-register decode
  always_comb begin
    w_state_nxt  = r_state;
    w_quo_nxt    = r_quo;
    w_rem_nxt    = r_rem;
    w_div_nxt    = r_div;
    w_sign_q_nxt = r_sign_q;
    w_count_nxt  = r_count;
    w_result_nxt = r_result;
    w_exc_nxt    = r_exc;
    w_rdy_nxt    = 1'b0;
    w_busy_nxt   = r_busy;

    if (ctrl_DIV) begin
      // A start is honoured in every state; any operation in flight is dropped.
      if (data_operandB == {WIDTH{1'b0}}) begin
        // Divide by zero: report after one extra cycle spent in DONE.
        w_state_nxt  = S_DONE;
        w_result_nxt = {WIDTH{1'b0}};
        w_exc_nxt    = 1'b1;
        w_busy_nxt   = 1'b1;
      end else begin
        w_state_nxt  = S_RUN;
        w_quo_nxt    = abs_val(data_operandA);
        w_div_nxt    = abs_val(data_operandB);
        w_rem_nxt    = {WIDTH{1'b0}};
        w_sign_q_nxt = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        w_count_nxt  = {CW{1'b0}};
        w_busy_nxt   = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_busy_nxt = 1'b0;
        end
        S_RUN: begin
          if (w_trial_neg) begin
            // Restore: keep the shifted remainder, quotient bit 0.
            w_rem_nxt = w_rem_sh[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
          end else begin
            w_rem_nxt = w_trial[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
          end
          w_count_nxt = r_count + CNT_ONE;
          if (r_count == CNT_LAST) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_FIX: begin
          if (r_sign_q) begin
            w_result_nxt = {WIDTH{1'b0}} - r_quo;
          end else begin
            w_result_nxt = r_quo;
          end
          w_exc_nxt   = 1'b0;
          w_rdy_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
        S_DONE: begin
          // Entered with RDY already raised from FIX, or with RDY low on the
          // divide-by-zero path; in the latter case raise it for one cycle.
          if (r_rdy) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_rdy_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_quo    <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_div    <= {WIDTH{1'b0}};
      r_sign_q <= 1'b0;
      r_count  <= {CW{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_quo    <= w_quo_nxt;
      r_rem    <= w_rem_nxt;
      r_div    <= w_div_nxt;
      r_sign_q <= w_sign_q_nxt;
      r_count  <= w_count_nxt;
      r_result <= w_result_nxt;
      r_exc    <= w_exc_nxt;
      r_rdy    <= w_rdy_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard testbench for seq_divider_32: the driver pushes expected
// quotient/exception/latency, a negedge monitor pops and compares on RDY.
module tb_seq_divider_32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic        exc;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed division in 64-bit arithmetic, truncating toward zero;
  // the low 32 bits give the wrapped result for -2^31 / -1.
  function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sbv;
    longint q;
    if (b == 32'd0) return 32'd0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    q   = sa / sbv;
    return q[31:0];
  endfunction

  // Monitor: every RDY pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) begin
      if (prev_rdy) begin
        n_checks++;
        n_fail++;
        $display("FAIL rdy_width: RDY high for 2 consecutive cycles, required 1 (cycle %0d)", cyc);
      end
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdy: got RDY=1, required no pulse (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", data_result, mon_e.q);
        chk("exception", {31'd0, data_exception}, {31'd0, mon_e.exc});
        chk("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
        chk("busy_at_rdy", {31'd0, busy}, 32'd1);
      end
    end
    prev_rdy = (data_resultRDY === 1'b1);
  end

  // Issue one start; an operation still pending is abandoned by it.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input bit release_after);
    exp_t e;
    @(negedge clock);
    #1;
    if (sb.size() > 0) e = sb.pop_back();
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    e.q     = model_q(a, b);
    e.exc   = (b == 32'd0);
    e.lat   = (b == 32'd0) ? 1 : 33;
    e.start = cyc + 1;
    sb.push_back(e);
    if (release_after) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
    end
  endtask

  // Wait until every expectation is consumed, then check the unit went idle.
  task automatic wait_idle();
    int k = 0;
    while (sb.size() > 0 && k < 100) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("rdy_after_done", {31'd0, data_resultRDY}, 32'd0);
  endtask

  task automatic do_reset_check();
    @(negedge clock);
    #1;
    reset    = 1'b1;
    ctrl_DIV = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("rst_result", data_result, 32'd0);
    chk("rst_exception", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_op(input bit allow_zero);
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = allow_zero ? 32'd0 : 32'd3;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(1, 20));
      4:       v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    do_reset_check();

    // Directed cases
    start(32'd100, 32'd7, 1'b1);                 wait_idle();
    start(32'hFFFF_FF9C, 32'd7, 1'b1);           wait_idle();
    start(32'd100, 32'hFFFF_FFF9, 1'b1);         wait_idle();
    start(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);   wait_idle();
    start(32'd5, 32'd9, 1'b1);                   wait_idle();
    start(32'd7, 32'd0, 1'b1);                   wait_idle();
    start(32'd8, 32'd2, 1'b1);                   wait_idle();
    start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_idle();
    start(32'h8000_0000, 32'd2, 1'b1);           wait_idle();

    // Restart mid-operation: only the second start reports
    start(32'd100, 32'd7, 1'b1);
    repeat (8) @(negedge clock);
    start(32'd81, 32'd9, 1'b1);
    wait_idle();

    // Reset mid-operation: no RDY, outputs cleared, then a clean division
    start(32'd100, 32'd7, 1'b1);
    repeat (19) @(negedge clock);
    do_reset_check();
    start(32'd50, 32'd5, 1'b1);
    wait_idle();

    // Start held high over several edges: only the last completes
    start(32'd1000, 32'd3, 1'b0);
    start(32'd77, 32'd0, 1'b0);
    start(32'hFFFF_FC18, 32'd10, 1'b1);
    wait_idle();

    // Randomised operations, some abandoned by an early restart
    for (int i = 0; i < 40; i++) begin
      start(rand_op(1'b0), rand_op($urandom_range(0, 4) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 36)) @(negedge clock);
      end else begin
        wait_idle();
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
